// File: rtl/taxi_pkg.sv
// taxi_pkg: Taxi grid dimensions, field widths and encoder FSM states shared with decode and step logic
package taxi_pkg;
  localparam int N_ROWS = 5;
  localparam int N_COLS = 5;
  localparam int N_PASS = 5;
  localparam int N_DEST = 4;
  localparam int TAXI_STATE_W = 9;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;
  localparam int PASS_W = 3;
  localparam int DEST_W = 2;
  typedef enum logic [2:0] {IDLE, S_COL, S_PASS, S_DEST, S_HOLD} enc_state_t;
endpackage

// File: rtl/taxi_field_check.sv
// taxi_field_check: combinational range check of the four Taxi observation fields
module taxi_field_check
  import taxi_pkg::*;
#(
  parameter int ROWS = N_ROWS,
  parameter int COLS = N_COLS,
  parameter int PASSES = N_PASS,
  parameter int DESTS = N_DEST
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [PASS_W-1:0] pass,
  input  logic [DEST_W-1:0] dest,
  output logic              err
);
  assign err = int'(row) >= ROWS || int'(col) >= COLS || int'(pass) >= PASSES || int'(dest) >= DESTS;
endmodule

// File: rtl/taxi_state_encoder.sv
// taxi_state_encoder: iterative Horner encoder of (row, col, pass, dest) into the flat Taxi observation index
module taxi_state_encoder
  import taxi_pkg::*;
#(
  parameter int N_ROWS = taxi_pkg::N_ROWS,
  parameter int N_COLS = taxi_pkg::N_COLS,
  parameter int N_PASS = taxi_pkg::N_PASS,
  parameter int N_DEST = taxi_pkg::N_DEST,
  parameter int STATE_W = TAXI_STATE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROW_W-1:0]   in_taxi_row,
  input  logic [COL_W-1:0]   in_taxi_col,
  input  logic [PASS_W-1:0]  in_pass_idx,
  input  logic [DEST_W-1:0]  in_dest_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               out_err,
  output logic [7:0]         err_cnt
);
  enc_state_t state, nxt;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [PASS_W-1:0] pass_q;
  logic [DEST_W-1:0] dest_q;
  logic [STATE_W-1:0] acc;
  logic err, err_q, accept;
  taxi_field_check #(
    .ROWS(N_ROWS),
    .COLS(N_COLS),
    .PASSES(N_PASS),
    .DESTS(N_DEST)
  ) u_check (
    .row(in_taxi_row),
    .col(in_taxi_col),
    .pass(in_pass_idx),
    .dest(in_dest_idx),
    .err(err)
  );
  assign in_ready = state == IDLE && !rst;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    nxt = state == IDLE   ? (accept ? S_COL : IDLE) :
          state == S_COL  ? S_PASS :
          state == S_PASS ? S_DEST :
          state == S_DEST ? S_HOLD :
          out_ready       ? IDLE : S_HOLD;
  end
  // Fields are captured only on accept so later input wiggles cannot leak in
  always_ff @(posedge clk) begin
    if (accept) begin
      row_q <= in_taxi_row;
      col_q <= in_taxi_col;
      pass_q <= in_pass_idx;
      dest_q <= in_dest_idx;
      err_q <= err;
    end
    if (state == S_COL) acc <= STATE_W'(row_q) * STATE_W'(N_COLS) + STATE_W'(col_q);
    else if (state == S_PASS) acc <= acc * STATE_W'(N_PASS) + STATE_W'(pass_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_state <= '0;
      out_err <= 1'b0;
      err_cnt <= '0;
    end else if (state == S_DEST) begin
      out_valid <= 1'b1;
      out_err <= err_q;
      out_state <= err_q ? '0 : acc * STATE_W'(N_DEST) + STATE_W'(dest_q);
    end else if (state == S_HOLD && out_ready) begin
      out_valid <= 1'b0;
      if (out_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule
